ov5640_reg_seq: RTL and testbench



---
 rtl/ov5640_reg_seq_if.sv | 29 ++
 rtl/ov5640_reg_seq.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ov5640_reg_seq.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov5640_reg_seq_if.sv
// Request/response bundle between the OV5640 register sequencer and the
// I2C/SCCB master.
//   wr_data_o  : {data, addr_lo, addr_hi, dev_addr}, byte0 goes out first
//   wr_cnt_o   : bytes to write, device byte included
//   rd_cnt_o   : bytes to read back
//   iic_en_o   : transfer request, held until the master reports busy
//   iic_mode_o : 1 = random read (write phase, restart, read phase)
//   iic_busy_i : master busy
//   rd_data_i  : last byte read by the master, valid when busy falls
// modport master: the sequencer side. modport slave: the I2C master side.
interface ov5640_reg_seq_if;
    logic [31:0] wr_data_o;
    logic [7:0]  wr_cnt_o;
    logic [7:0]  rd_cnt_o;
    logic        iic_en_o;
    logic        iic_mode_o;
    logic        iic_busy_i;
    logic [7:0]  rd_data_i;

    modport master (
        output wr_data_o, wr_cnt_o, rd_cnt_o, iic_en_o, iic_mode_o,
        input  iic_busy_i, rd_data_i
    );

    modport slave (
        input  wr_data_o, wr_cnt_o, rd_cnt_o, iic_en_o, iic_mode_o,
        output iic_busy_i, rd_data_i
    );
endinterface

// File: rtl/ov5640_reg_seq.sv
// OV5640 register-table sequencer. After a power-up wait it reads the chip
// ID (0x300A/0x300B), then walks an external registered ROM, turning each
// entry into a 4-byte SCCB write, a millisecond delay, or an end marker.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : one-cycle start pulse (honoured in IDLE/DONE/ERR only)
//   tab_idx_o      : ROM index; tab_dat_i = {addr[15:0], data[7:0]} one
//                    cycle after the index changes
//   iic            : request/response bundle to the I2C master
//   cfg_busy_o     : sequence running
//   cfg_done_o     : table finished (level)
//   cfg_err_o      : ID mismatch or request timeout (level)
//   id_o           : captured chip ID
module ov5640_reg_seq #(
    parameter logic [7:0]  DEV_ADDR     = 8'h78,
    parameter int unsigned TAB_LEN      = 256,
    parameter int unsigned IDX_W        = 8,
    parameter int unsigned CLK_FREQ_KHZ = 50000,
    parameter int unsigned PWR_DLY_MS   = 20,
    parameter logic [15:0] ID_VAL       = 16'h5640,
    parameter logic [15:0] REQ_TO       = 16'd65535,
    parameter logic [7:0]  GAP          = 8'd32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic [IDX_W-1:0]   tab_idx_o,
    input  logic [23:0]        tab_dat_i,
    ov5640_reg_seq_if.master   iic,
    output logic               cfg_busy_o,
    output logic               cfg_done_o,
    output logic               cfg_err_o,
    output logic [15:0]        id_o
);

    localparam int MS_W = (CLK_FREQ_KHZ > 1) ? $clog2(CLK_FREQ_KHZ) : 1;
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(CLK_FREQ_KHZ - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TAB_LEN - 1);
    localparam logic [15:0]      PWR_MS   = 16'(PWR_DLY_MS);

    typedef enum logic [3:0] {
        S_IDLE, S_PWR, S_IDH, S_IDL, S_FETCH, S_DEC,
        S_REQ, S_WAIT, S_GAPW, S_DLY, S_DONE, S_ERR
    } state_e;

    // Which transfer the shared REQ/WAIT/GAPW handshake is serving.
    typedef enum logic [1:0] {PH_IDH, PH_IDL, PH_WR} phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       wd_q, wd_d;
    logic [7:0]        wc_q, wc_d;
    logic [7:0]        rc_q, rc_d;
    logic              en_q, en_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       id_q, id_d;
    logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic [15:0]       ms_left_q, ms_left_d;
    logic [15:0]       to_cnt_q, to_cnt_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;

    logic        ms_tick;
    logic        at_last;
    logic        gap_end;
    logic        start_ok;
    logic [15:0] tab_addr;
    logic [7:0]  tab_val;

    assign ms_tick  = (ms_cnt_q == MS_LAST);
    assign at_last  = (idx_q == IDX_LAST);
    assign gap_end  = (GAP == 8'd0) || (gap_cnt_q == GAP - 8'd1);
    // A master still busy from an aborted transfer must finish first.
    assign start_ok = start_i && !iic.iic_busy_i;
    assign tab_addr = tab_dat_i[23:8];
    assign tab_val  = tab_dat_i[7:0];

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        wd_d      = wd_q;
        wc_d      = wc_q;
        rc_d      = rc_q;
        en_d      = en_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        id_d      = id_q;
        ms_left_d = ms_left_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ms_cnt_d  = ms_tick ? '0 : ms_cnt_q + MS_W'(1);

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_ok) begin
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    idx_d     = '0;
                    ms_left_d = PWR_MS;
                    state_d   = S_PWR;
                end
            end
            S_PWR: begin
                if (ms_left_q == 16'd0) begin
                    state_d = S_IDH;
                end else if (ms_tick) begin
                    ms_left_d = ms_left_q - 16'd1;
                    if (ms_left_q == 16'd1) state_d = S_IDH;
                end
            end
            S_IDH, S_IDL: begin
                wd_d = {8'h00, (state_q == S_IDH) ? 8'h0A : 8'h0B,
                        8'h30, DEV_ADDR};
                wc_d     = 8'd3;
                rc_d     = 8'd1;
                mode_d   = 1'b1;
                phase_d  = (state_q == S_IDH) ? PH_IDH : PH_IDL;
                en_d     = 1'b1;
                to_cnt_d = 16'd0;
                state_d  = S_REQ;
            end
            S_FETCH: state_d = S_DEC;
            S_DEC: begin
                unique case (1'b1)
                    (tab_addr == 16'hFFFE): state_d = S_DONE;
                    (tab_addr == 16'hFFFF): begin
                        if (tab_val == 8'd0) begin
                            state_d = at_last ? S_DONE : S_FETCH;
                            idx_d   = at_last ? idx_q : idx_q + IDX_W'(1);
                        end else begin
                            ms_left_d = {8'h00, tab_val};
                            state_d   = S_DLY;
                        end
                    end
                    default: begin
                        wd_d = {tab_val, tab_addr[7:0],
                                tab_addr[15:8], DEV_ADDR};
                        wc_d     = 8'd4;
                        rc_d     = 8'd0;
                        mode_d   = 1'b0;
                        phase_d  = PH_WR;
                        en_d     = 1'b1;
                        to_cnt_d = 16'd0;
                        state_d  = S_REQ;
                    end
                endcase
            end
            S_REQ: begin
                if (iic.iic_busy_i) begin
                    en_d    = 1'b0;
                    state_d = S_WAIT;
                end else if (to_cnt_q == REQ_TO - 16'd1) begin
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            S_WAIT: begin
                if (!iic.iic_busy_i) begin
                    if (phase_q == PH_IDH) id_d[15:8] = iic.rd_data_i;
                    if (phase_q == PH_IDL) id_d[7:0]  = iic.rd_data_i;
                    gap_cnt_d = 8'd0;
                    state_d   = S_GAPW;
                end
            end
            S_GAPW: begin
                if (gap_end) begin
                    unique case (phase_q)
                        PH_IDH: state_d = S_IDL;
                        PH_IDL: state_d = (id_q == ID_VAL) ? S_FETCH : S_ERR;
                        default: begin
                            state_d = at_last ? S_DONE : S_FETCH;
                            idx_d   = at_last ? idx_q : idx_q + IDX_W'(1);
                        end
                    endcase
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            S_DLY: begin
                if (ms_tick) begin
                    if (ms_left_q <= 16'd1) begin
                        state_d = at_last ? S_DONE : S_FETCH;
                        idx_d   = at_last ? idx_q : idx_q + IDX_W'(1);
                    end else begin
                        ms_left_d = ms_left_q - 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
        if (state_d == S_ERR) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
            en_d   = 1'b0;
        end
        // Restart the ms phase so a delay is a whole number of ms.
        if ((state_d == S_PWR || state_d == S_DLY) && state_d != state_q)
            ms_cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_IDH;
            idx_q     <= '0;
            wd_q      <= '0;
            wc_q      <= '0;
            rc_q      <= '0;
            en_q      <= 1'b0;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            id_q      <= '0;
            ms_cnt_q  <= '0;
            ms_left_q <= '0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            wd_q      <= wd_d;
            wc_q      <= wc_d;
            rc_q      <= rc_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            id_q      <= id_d;
            ms_cnt_q  <= ms_cnt_d;
            ms_left_q <= ms_left_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign tab_idx_o      = idx_q;
    assign iic.wr_data_o  = wd_q;
    assign iic.wr_cnt_o   = wc_q;
    assign iic.rd_cnt_o   = rc_q;
    assign iic.iic_en_o   = en_q;
    assign iic.iic_mode_o = mode_q;
    assign cfg_busy_o     = busy_q;
    assign cfg_done_o     = done_q;
    assign cfg_err_o      = err_q;
    assign id_o           = id_q;

endmodule

// File: tb/tb_ov5640_reg_seq.sv
// Testbench for ov5640_reg_seq: behavioural I2C master, registered ROM and
// a table-walking reference model of the expected transfer list.
module tb_ov5640_reg_seq;
    localparam int K    = 20;
    localparam int PWR  = 2;
    localparam int RTO  = 40;
    localparam int GAPC = 4;
    localparam int TL   = 4;
    localparam int IW   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [IW-1:0] tab_idx;
    logic [23:0] tab_dat;
    logic cfg_busy, cfg_done, cfg_err;
    logic [15:0] id;

    always #5 clk = ~clk;

    ov5640_reg_seq_if bus();

    ov5640_reg_seq #(
        .DEV_ADDR(8'h78), .TAB_LEN(TL), .IDX_W(IW), .CLK_FREQ_KHZ(K),
        .PWR_DLY_MS(PWR), .ID_VAL(16'h5640), .REQ_TO(16'(RTO)),
        .GAP(8'(GAPC))
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .tab_idx_o(tab_idx), .tab_dat_i(tab_dat), .iic(bus),
        .cfg_busy_o(cfg_busy), .cfg_done_o(cfg_done),
        .cfg_err_o(cfg_err), .id_o(id)
    );

    logic [23:0] rom [TL];
    always @(posedge clk) tab_dat <= rom[tab_idx];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic mode; logic [31:0] wd; logic [7:0] wc; logic [7:0] rc;
        int t_req; int t_end; bit stable;
    } txn_t;
    typedef struct {
        logic mode; logic [31:0] wd; logic [7:0] wc; logic [7:0] rc;
        int lo; int hi;
    } exp_t;

    txn_t log_q[$];
    exp_t expq[$];
    logic [7:0] rdq[$];
    bit mst_on = 1'b1;
    bit mst_hold = 1'b0;
    bit exp_done, exp_err;
    int exp_idx;
    logic [15:0] exp_id;
    int npass = 0;
    int nfail = 0;

    // Behavioural I2C master
    initial begin
        bus.iic_busy_i = 1'b0;
        bus.rd_data_i  = 8'h00;
        forever begin
            @(negedge clk);
            if (mst_on && bus.iic_en_o && !bus.iic_busy_i) begin
                txn_t t;
                t.mode = bus.iic_mode_o; t.wd = bus.wr_data_o;
                t.wc = bus.wr_cnt_o; t.rc = bus.rd_cnt_o;
                t.t_req = cyc;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                bus.iic_busy_i = 1'b1;
                repeat ($urandom_range(2, 8)) @(negedge clk);
                while (mst_hold) @(negedge clk);
                t.stable = (bus.wr_data_o == t.wd) && (bus.wr_cnt_o == t.wc)
                    && (bus.rd_cnt_o == t.rc) && (bus.iic_mode_o == t.mode);
                if (t.mode && rdq.size() > 0) bus.rd_data_i = rdq.pop_front();
                bus.iic_busy_i = 1'b0;
                t.t_end = cyc;
                log_q.push_back(t);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int v, input int lo,
                           input int hi);
        assert (v >= lo && v <= hi) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=[%0d..%0d]", tag, v, lo, hi);
        end
    endtask

    // Reference: the expected transfer list walked from the table rules.
    task automatic build_model(input logic [7:0] b0, input logic [7:0] b1);
        int ms;
        int n;
        expq.delete();
        exp_id = {b0, b1};
        expq.push_back('{1'b1, 32'h000A3078, 8'd3, 8'd1, PWR*K, PWR*K+4});
        expq.push_back('{1'b1, 32'h000B3078, 8'd3, 8'd1, GAPC+2, GAPC+6});
        exp_done = 1'b0; exp_err = 1'b1; exp_idx = 0;
        if (exp_id != 16'h5640) return;
        exp_done = 1'b1; exp_err = 1'b0; exp_idx = TL - 1;
        ms = 0; n = 0;
        for (int i = 0; i < TL; i++) begin
            logic [15:0] a;
            logic [7:0] v;
            a = rom[i][23:8];
            v = rom[i][7:0];
            if (a == 16'hFFFE) begin
                exp_idx = i;
                break;
            end else if (a == 16'hFFFF) begin
                ms += int'(v); n++;
            end else begin
                expq.push_back('{1'b0, {v, a[7:0], a[15:8], 8'h78}, 8'd4,
                                 8'd0, GAPC+2+ms*K, GAPC+6+ms*K+2*n});
                ms = 0; n = 0;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_cfg(input string tag);
        int t0;
        int n;
        int m;
        log_q.delete();
        @(negedge clk); start = 1'b1; t0 = cyc;
        @(negedge clk); start = 1'b0;
        chk({tag, ".busy_on"}, {cfg_busy, cfg_done, cfg_err}, 3'b100);
        n = 0;
        while (!(cfg_done || cfg_err) && n < 4000) begin
            @(negedge clk); n++;
        end
        chk_rng({tag, ".finish_in_time"}, n, 0, 3999);
        repeat (2) @(negedge clk);
        chk({tag, ".done"}, cfg_done, exp_done);
        chk({tag, ".err"}, cfg_err, exp_err);
        chk({tag, ".busy_off"}, cfg_busy, 1'b0);
        chk({tag, ".id"}, id, exp_id);
        chk({tag, ".idx"}, tab_idx, exp_idx);
        chk({tag, ".en_low"}, bus.iic_en_o, 1'b0);
        chk({tag, ".ntxn"}, log_q.size(), expq.size());
        m = (log_q.size() < expq.size()) ? log_q.size() : expq.size();
        for (int i = 0; i < m; i++) begin
            int d;
            d = (i == 0) ? log_q[0].t_req - t0 : log_q[i].t_req - log_q[i-1].t_end;
            chk($sformatf("%s.mode%0d", tag, i), log_q[i].mode, expq[i].mode);
            chk($sformatf("%s.wd%0d", tag, i), log_q[i].wd, expq[i].wd);
            chk($sformatf("%s.cnt%0d", tag, i), {log_q[i].wc, log_q[i].rc},
                {expq[i].wc, expq[i].rc});
            chk($sformatf("%s.stable%0d", tag, i), log_q[i].stable, 1'b1);
            chk_rng($sformatf("%s.space%0d", tag, i), d, expq[i].lo, expq[i].hi);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".wd"}, bus.wr_data_o, 32'h0);
        chk({tag, ".cnt"}, {bus.wr_cnt_o, bus.rd_cnt_o}, 16'h0);
        chk({tag, ".en_mode"}, {bus.iic_en_o, bus.iic_mode_o}, 2'b00);
        chk({tag, ".status"}, {cfg_busy, cfg_done, cfg_err}, 3'b000);
        chk({tag, ".id"}, id, 16'h0);
        chk({tag, ".idx"}, tab_idx, 0);
    endtask

    initial begin
        int n;
        int cnt;
        rom[0] = 24'h300882; rom[1] = 24'hFFFF02;
        rom[2] = 24'h310311; rom[3] = 24'hFFFE00;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Normal sequence
        rdq = '{8'h56, 8'h40};
        build_model(8'h56, 8'h40);
        run_cfg("normal");

        // Wrong ID
        rdq = '{8'h56, 8'h42};
        build_model(8'h56, 8'h42);
        run_cfg("wrong_id");

        // Request timeout
        rdq.delete();
        mst_on = 1'b0;
        pulse_start();
        n = 0; cnt = 0;
        while (!cfg_err && n < 1000) begin
            if (bus.iic_en_o) cnt++;
            @(negedge clk); n++;
        end
        chk("timeout.en_cycles", cnt, RTO);
        chk("timeout.state", {cfg_err, cfg_done, cfg_busy, bus.iic_en_o}, 4'b1000);
        mst_on = 1'b1;

        // No end marker: four writes
        for (int i = 0; i < TL; i++)
            rom[i] = {16'(16'h3000 + 16'(i * 16'h0111)), 8'(8'hA0 + i)};
        rdq = '{8'h56, 8'h40};
        build_model(8'h56, 8'h40);
        run_cfg("no_end");

        // Reset mid-transfer
        rdq = '{8'hAA};
        mst_hold = 1'b1;
        pulse_start();
        n = 0;
        while (!bus.iic_busy_i && n < 500) begin @(negedge clk); n++; end
        chk("rst_mid.busy_seen", bus.iic_busy_i, 1'b1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_reset_vals("rst_mid");
        pulse_start();
        repeat (4) @(negedge clk);
        chk("rst_mid.start_blocked", {cfg_busy, bus.iic_en_o}, 2'b00);
        mst_hold = 1'b0;
        n = 0;
        while (bus.iic_busy_i && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        rom[0] = 24'h300882; rom[1] = 24'hFFFF02;
        rom[2] = 24'h310311; rom[3] = 24'hFFFE00;
        rdq = '{8'h56, 8'h40};
        build_model(8'h56, 8'h40);
        run_cfg("rst_rerun");

        // start_i during a 5 ms delay
        rom[0] = 24'h300811; rom[1] = 24'hFFFF05;
        rom[2] = 24'h300922; rom[3] = 24'hFFFE00;
        rdq = '{8'h56, 8'h40};
        build_model(8'h56, 8'h40);
        fork
            run_cfg("dly_start");
            begin
                int w;
                w = 0;
                while (log_q.size() < 3 && w < 2000) begin @(negedge clk); w++; end
                repeat (2*K) @(negedge clk);
                start = 1'b1;
                @(negedge clk); start = 1'b0;
                @(negedge clk);
                chk("dly_start.still_busy", {cfg_busy, tab_idx}, {1'b1, 2'd1});
            end
        join

        // Randomized tables
        for (int it = 0; it < 4; it++) begin
            logic [7:0] b1;
            for (int i = 0; i < TL; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 6) rom[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
                else if (r < 9) rom[i] = {16'hFFFF, 8'($urandom_range(0, 3))};
                else rom[i] = {16'hFFFE, 8'($urandom)};
            end
            b1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h40;
            rdq = '{8'h56, b1};
            build_model(8'h56, b1);
            run_cfg($sformatf("rand%0d", it));
        end

        $display("%0d/%0d checks passed", npass, npass + nfail);
        $finish;
    end
endmodule
